// File: rtl/rtl_bmu_iter_count.sv
// Iterative Zbb count unit (clz / ctz / cpop): examines CHUNK operand bits per cycle
// and returns a zero-extended 6-bit count over a valid/ready handshake.

package rtl_alu_pkg;
   typedef struct packed {
      logic add;
      logic sub;
      logic land;
      logic lor;
      logic lxor;
      logic clz;
      logic ctz;
      logic cpop;
   } rtl_alu_pkt_t;
endpackage

module rtl_bmu_iter_count
   import rtl_alu_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_in,
   input  rtl_alu_pkt_t ap,
   input  logic [31:0]  a_in,
   output logic         ready_out,
   input  logic         flush,
   output logic         valid_out,
   input  logic         ready_in,
   output logic [31:0]  result,
   output logic         busy
);

   localparam int N     = 32 / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_CNT, S_DONE} state_t;
   typedef enum logic [1:0] {OP_NOP, OP_CLZ, OP_CTZ, OP_CPOP} op_t;

   state_t           state_reg, state_next;
   op_t              op_reg, op_next;
   logic [31:0]      operand_reg, operand_next;
   logic [5:0]       count_reg, count_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             found_reg, found_next;

   logic [CHUNK-1:0] chunk_hi, chunk_lo;
   logic             unused_pkt_bits;

   // Only the three count-op flags matter; the rest of the packet is decode's business.
   assign unused_pkt_bits = ^{ap.add, ap.sub, ap.land, ap.lor, ap.lxor};

   // The operand is shifted each iteration, so the chunk of interest is always at a fixed edge.
   assign chunk_hi = operand_reg[31 -: CHUNK];
   assign chunk_lo = operand_reg[CHUNK-1:0];

   function automatic logic [5:0] lead_zeros(input logic [CHUNK-1:0] c);
      logic [5:0] n;
      logic       hit;
      n   = '0;
      hit = 1'b0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (c[i])
            hit = 1'b1;
         else if (!hit)
            n = n + 6'd1;
      end
      return n;
   endfunction

   function automatic logic [5:0] trail_zeros(input logic [CHUNK-1:0] c);
      logic [5:0] n;
      logic       hit;
      n   = '0;
      hit = 1'b0;
      for (int i = 0; i < CHUNK; i++) begin
         if (c[i])
            hit = 1'b1;
         else if (!hit)
            n = n + 6'd1;
      end
      return n;
   endfunction

   function automatic logic [5:0] pop_count(input logic [CHUNK-1:0] c);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < CHUNK; i++)
         n = n + {5'd0, c[i]};
      return n;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         op_reg      <= OP_NOP;
         operand_reg <= '0;
         count_reg   <= '0;
         idx_reg     <= '0;
         found_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         op_reg      <= op_next;
         operand_reg <= operand_next;
         count_reg   <= count_next;
         idx_reg     <= idx_next;
         found_reg   <= found_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      op_next      = op_reg;
      operand_next = operand_reg;
      count_next   = count_reg;
      idx_next     = idx_reg;
      found_next   = found_reg;
      case (state_reg)
         S_IDLE: begin
            if (valid_in && !flush) begin
               operand_next = a_in;
               if (ap.clz)       op_next = OP_CLZ;
               else if (ap.ctz)  op_next = OP_CTZ;
               else if (ap.cpop) op_next = OP_CPOP;
               else              op_next = OP_NOP;
               count_next = '0;
               idx_next   = '0;
               found_next = 1'b0;
               state_next = S_CNT;
            end
         end
         S_CNT: begin
            if (flush) begin
               state_next = S_IDLE;
            end else begin
               case (op_reg)
                  OP_CLZ: begin
                     if (!found_reg) count_next = count_reg + lead_zeros(chunk_hi);
                     found_next   = found_reg | (chunk_hi != '0);
                     operand_next = operand_reg << CHUNK;
                  end
                  OP_CTZ: begin
                     if (!found_reg) count_next = count_reg + trail_zeros(chunk_lo);
                     found_next   = found_reg | (chunk_lo != '0);
                     operand_next = operand_reg >> CHUNK;
                  end
                  OP_CPOP: begin
                     count_next   = count_reg + pop_count(chunk_lo);
                     operand_next = operand_reg >> CHUNK;
                  end
                  default: ;
               endcase
               // Fixed latency: every op, including NOP, walks all N chunks.
               idx_next = idx_reg + IDX_W'(1);
               if (idx_reg == LAST_IDX) state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (flush || ready_in) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign ready_out = (state_reg == S_IDLE);
   assign valid_out = (state_reg == S_DONE);
   assign busy      = (state_reg != S_IDLE);
   assign result    = (state_reg == S_DONE) ? {26'd0, count_reg} : 32'd0;

endmodule

// File: tb/tb_rtl_bmu_iter_count.sv
// Directed bench for rtl_bmu_iter_count: per-feature tasks with inline expected values.

module tb_rtl_bmu_iter_count;
   import rtl_alu_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_in;
   rtl_alu_pkt_t ap;
   logic [31:0]  a_in;
   logic         ready_out;
   logic         flush;
   logic         valid_out;
   logic         ready_in;
   logic [31:0]  result;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   rtl_bmu_iter_count #(.CHUNK(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ap        (ap),
      .a_in      (a_in),
      .ready_out (ready_out),
      .flush     (flush),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // op: 0=NOP 1=clz 2=ctz 3=cpop 4=clz+cpop
   function automatic rtl_alu_pkt_t make_pkt(input int op);
      rtl_alu_pkt_t p;
      p = '0;
      p.add  = 1'b1;
      p.clz  = (op == 1) || (op == 4);
      p.ctz  = (op == 2);
      p.cpop = (op == 3) || (op == 4);
      return p;
   endfunction

   // Present one request for a single edge, then scramble the inputs to prove they were latched.
   task automatic issue(input int op, input logic [31:0] a);
      @(negedge clk);
      valid_in = 1'b1;
      ap       = make_pkt(op);
      a_in     = a;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      ap       = make_pkt(3);
      a_in     = $urandom;
   endtask

   // Edges until valid_out (0 if the bound expires); consumes the result when ready_in is high.
   task automatic wait_result(output int lat, output logic [31:0] res);
      lat = 0;
      res = 32'hDEAD_BEEF;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (valid_out) begin
            lat = i + 1;
            res = result;
            break;
         end
      end
      if (lat != 0 && ready_in) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_op(input string name, input int op, input logic [31:0] a,
                         input logic [31:0] exp);
      int          lat;
      logic [31:0] res;
      issue(op, a);
      wait_result(lat, res);
      n_checks++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL %s latency: got %0d edges, expected 4", name, lat);
      end
      n_checks++;
      if (res !== exp) begin
         n_fail++;
         $display("FAIL %s result: got %0d, expected %0d", name, res, exp);
      end
      $display("op %s a=%08h result=%0d latency=%0d", name, a, res, lat);
   endtask

   task automatic test_reset();
      rst = 1'b1; valid_in = 1'b0; ap = '0; a_in = '0; flush = 1'b0; ready_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({ready_out, valid_out, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_flags: got rdy/vld/busy=%b, expected 100", {ready_out, valid_out, busy});
      end
      n_checks++;
      if (result !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_result: got %0d, expected 0", result);
      end
      @(negedge clk);
      rst = 1'b0;
      $display("reset released");
   endtask

   task automatic test_clz_ctz();
      run_op("clz_00010000", 1, 32'h0001_0000, 32'd15);
      run_op("ctz_00010000", 2, 32'h0001_0000, 32'd16);
   endtask

   task automatic test_cpop();
      run_op("cpop_F0F00001", 3, 32'hF0F0_0001, 32'd9);
      run_op("cpop_FFFFFFFF", 3, 32'hFFFF_FFFF, 32'd32);
   endtask

   task automatic test_boundaries();
      run_op("clz_zero", 1, 32'h0000_0000, 32'd32);
      run_op("ctz_zero", 2, 32'h0000_0000, 32'd32);
      run_op("clz_80000000", 1, 32'h8000_0000, 32'd0);
      run_op("ctz_80000000", 2, 32'h8000_0000, 32'd31);
      run_op("ctz_00000100", 2, 32'h0000_0100, 32'd8);
   endtask

   task automatic test_priority();
      run_op("clz_cpop_0000000F", 4, 32'h0000_000F, 32'd28);
      run_op("nop_FFFFFFFF", 0, 32'hFFFF_FFFF, 32'd0);
   endtask

   task automatic test_backpressure();
      int          lat;
      logic [31:0] res;
      ready_in = 1'b0;
      issue(1, 32'h0001_0000);
      wait_result(lat, res);
      n_checks++;
      if (lat !== 4 || res !== 32'd15) begin
         n_fail++;
         $display("FAIL bp_first: got lat=%0d res=%0d, expected lat=4 res=15", lat, res);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (valid_out !== 1'b1 || result !== 32'd15 || ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got vld=%b res=%0d rdy=%b, expected vld=1 res=15 rdy=0",
                     c, valid_out, result, ready_out);
         end
      end
      ready_in = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (valid_out !== 1'b0 || ready_out !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: got vld=%b rdy=%b busy=%b, expected 0 1 0",
                  valid_out, ready_out, busy);
      end
      $display("backpressure held 3 cycles, released");
   endtask

   task automatic test_flush();
      logic seen_valid;
      issue(3, 32'hFFFF_FFFF);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      n_checks++;
      if (valid_out !== 1'b0 || ready_out !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_cnt: got vld=%b rdy=%b busy=%b, expected 0 1 0",
                  valid_out, ready_out, busy);
      end
      seen_valid = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (valid_out) seen_valid = 1'b1;
      end
      n_checks++;
      if (seen_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_no_valid: got valid_out=1 after flush, expected 0");
      end
      // flush in IDLE must block an otherwise valid request
      @(negedge clk);
      valid_in = 1'b1; ap = make_pkt(1); a_in = 32'h1; flush = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0; flush = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_idle_block: got busy=%b rdy=%b, expected 0 1", busy, ready_out);
      end
      $display("flush in CNT and IDLE exercised");
      run_op("clz_after_flush", 1, 32'h0000_0001, 32'd31);
   endtask

   task automatic test_reset_mid();
      int          lat;
      logic [31:0] res;
      ready_in = 1'b0;
      issue(2, 32'h0000_0010);
      wait_result(lat, res);
      n_checks++;
      if (lat !== 4 || res !== 32'd4) begin
         n_fail++;
         $display("FAIL rstmid_first: got lat=%0d res=%0d, expected lat=4 res=4", lat, res);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({ready_out, valid_out, busy} !== 3'b100 || result !== 32'd0) begin
         n_fail++;
         $display("FAIL rstmid: got rdy/vld/busy=%b res=%0d, expected 100 res=0",
                  {ready_out, valid_out, busy}, result);
      end
      @(negedge clk);
      rst = 1'b0;
      ready_in = 1'b1;
      $display("async reset in DONE exercised");
      run_op("ctz_after_reset", 2, 32'h0000_0010, 32'd4);
   endtask

   initial begin
      test_reset();
      test_clz_ctz();
      test_cpop();
      test_boundaries();
      test_priority();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
